// File: rtl/m_conv_map_writer_2.sv
`default_nettype none
// ============================================================================
// Module   : m_conv_map_writer_2
// Purpose  : Layer-2 feature-map RAM writer. ReLU + 8-bit quantisation of the
//            conv stream, row-major write, hold until the reader releases.
// Revision : 1.0  initial release
// ============================================================================
module m_conv_map_writer_2 #(
  parameter int MAP_W  = 26,
  parameter int MAP_H  = 26,
  parameter int ADDR_W = 10,
  parameter int ACC_W  = 16,
  parameter int SHIFT  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    conv_valid,
  input  logic signed [ACC_W-1:0] conv_data,
  output logic                    in_ready,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       ram_write_addr,
  output logic [7:0]              d_out,
  output logic                    layer_2_relu_begin,
  input  logic                    layer_2_ready,
  output logic [7:0]              frame_count,
  output logic                    overflow_err
);

  localparam int                c_MAP_SIZE  = MAP_W * MAP_H;
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_MAP_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_ready_q;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_d_out;
  logic              r_begin;
  logic [7:0]        r_frame_count;
  logic              r_ovf;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_release;
  logic [ACC_W-1:0]  w_shifted;
  logic [7:0]        w_q;

  assign w_in_ready = (r_state != ST_HOLD);
  assign w_accept   = conv_valid & w_in_ready;
  // Only a fresh 0->1 edge while the reader has been told to run counts.
  assign w_release  = (r_state == ST_HOLD) & r_begin & layer_2_ready & ~r_ready_q;

  // ReLU, scale down, saturate to 8 bits.
  assign w_shifted = conv_data >> SHIFT;
  assign w_q = conv_data[ACC_W-1]        ? 8'd0  :
               (|w_shifted[ACC_W-1:8])   ? 8'hFF :
                                           w_shifted[7:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= '0;
      r_ready_q     <= 1'b0;
      r_wr_en       <= 1'b0;
      r_addr        <= '0;
      r_d_out       <= 8'd0;
      r_begin       <= 1'b0;
      r_frame_count <= 8'd0;
      r_ovf         <= 1'b0;
    end else begin
      r_ready_q <= layer_2_ready;
      r_wr_en   <= w_accept;
      if (w_accept) begin
        r_addr  <= r_wr_ptr;
        r_d_out <= w_q;
      end
      if (conv_valid && !w_in_ready) begin
        r_ovf <= 1'b1;
      end

      case (r_state)
        ST_IDLE, ST_FILL: begin
          r_begin <= 1'b0;
          if (w_accept) begin
            if (r_wr_ptr == c_LAST_ADDR) begin
              r_wr_ptr <= '0;
              r_state  <= ST_HOLD;
            end else begin
              r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
              r_state  <= ST_FILL;
            end
          end
        end
        ST_HOLD: begin
          // begin rises one cycle after the final write strobe
          if (w_release) begin
            r_begin       <= 1'b0;
            r_state       <= ST_IDLE;
            r_frame_count <= r_frame_count + 8'd1;
          end else begin
            r_begin <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_begin <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready           = w_in_ready;
  assign wr_en              = r_wr_en;
  assign ram_write_addr     = r_addr;
  assign d_out              = r_d_out;
  assign layer_2_relu_begin = r_begin;
  assign frame_count        = r_frame_count;
  assign overflow_err       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_m_conv_map_writer_2.sv
`default_nettype none
// Randomised scoreboard bench for m_conv_map_writer_2 with a frame-level reference model.
module tb_m_conv_map_writer_2;

  localparam int MAP_W  = 26;
  localparam int MAP_H  = 26;
  localparam int ADDR_W = 10;
  localparam int ACC_W  = 16;
  localparam int SHIFT  = 4;
  localparam int N      = MAP_W * MAP_H;

  logic              clk = 1'b0;
  logic              rst;
  logic              conv_valid;
  logic [ACC_W-1:0]  conv_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] ram_write_addr;
  logic [7:0]        d_out;
  logic              layer_2_relu_begin;
  logic              layer_2_ready;
  logic [7:0]        frame_count;
  logic              overflow_err;

  m_conv_map_writer_2 #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .conv_valid(conv_valid),
    .conv_data(conv_data),
    .in_ready(in_ready),
    .wr_en(wr_en),
    .ram_write_addr(ram_write_addr),
    .d_out(d_out),
    .layer_2_relu_begin(layer_2_relu_begin),
    .layer_2_ready(layer_2_ready),
    .frame_count(frame_count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  // Reference model state
  bit m_valid    = 1'b0;
  bit m_hold     = 1'b0;
  int m_cnt      = 0;
  bit m_ovf      = 1'b0;
  int m_frames   = 0;
  bit m_ready_q  = 1'b0;
  int hold_age   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int q_ref(input logic [ACC_W-1:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) return 0;
    v = v / (1 << SHIFT);
    if (v > 255) return 255;
    return v;
  endfunction

  // One clock: check registered status, drive inputs, advance model, wait edge.
  task automatic step(input bit v, input logic [ACC_W-1:0] d, input bit r);
    wr_t w;
    bit  rel;
    if (m_valid) begin
      chk("in_ready", int'(in_ready), int'(!m_hold));
      chk("relu_begin", int'(layer_2_relu_begin), int'(m_hold && hold_age >= 2));
      chk("overflow_err", int'(overflow_err), int'(m_ovf));
      chk("frame_count", int'(frame_count), m_frames % 256);
    end
    conv_valid    = v;
    conv_data     = d;
    layer_2_ready = r;
    if (!rst) begin
      m_valid   = 1'b1;
      m_hold    = 1'b0;
      m_cnt     = 0;
      m_ovf     = 1'b0;
      m_frames  = 0;
      m_ready_q = 1'b0;
      hold_age  = 0;
    end else begin
      rel = m_hold && hold_age >= 2 && r && !m_ready_q;
      if (v && m_hold) m_ovf = 1'b1;
      if (v && !m_hold) begin
        w.addr = m_cnt;
        w.data = q_ref(d);
        exp_q.push_back(w);
        m_cnt++;
        if (m_cnt == N) begin
          m_cnt    = 0;
          m_hold   = 1'b1;
          hold_age = 0;
        end
      end
      if (rel) begin
        m_hold = 1'b0;
        m_frames++;
        hold_age = 0;
      end
      m_ready_q = r;
    end
    @(posedge clk);
    #1;
    if (m_hold) hold_age++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) begin
      step(1'b1, ACC_W'($urandom), 1'b0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_addr", int'(ram_write_addr), 0);
      chk("rst_d_out", int'(d_out), 0);
    end
    rst = 1'b1;
  endtask

  task automatic release_map();
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
  endtask

  task automatic rand_step(input bit r);
    step($urandom_range(0, 3) != 0, ACC_W'($urandom), r);
  endtask

  // Scoreboard monitor
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("wr_en_unexpected", int'(wr_en), 0);
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", int'(ram_write_addr), w.addr);
          chk("wr_data", int'(d_out), w.data);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [ACC_W-1:0] qv [6];
    int guard;
    qv[0] = 16'hFFFB; qv[1] = 16'h0000; qv[2] = 16'h0130;
    qv[3] = 16'h0FF0; qv[4] = 16'h7FFF; qv[5] = 16'h000F;
    rst = 1'b0; conv_valid = 1'b0; conv_data = '0; layer_2_ready = 1'b0;

    do_reset(3);

    // Directed full frame: data n<<4 quantises to n, saturating at 255
    for (int n = 0; n < N; n++) step(1'b1, ACC_W'(n << 4), 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    repeat (2) step(1'b1, ACC_W'($urandom), 1'b0);
    repeat (2) step(1'b0, '0, 1'b0);
    release_map();

    // Quantisation corners, then random fill with ready held high (stale)
    foreach (qv[i]) step(1'b1, qv[i], 1'b1);
    guard = 0;
    while (!m_hold && guard < 5000) begin rand_step(1'b1); guard++; end
    chk("frame2_complete", int'(m_hold), 1);
    repeat (20) step(1'b0, '0, 1'b1);
    release_map();

    // Partial frame, reset, then a complete frame with random gaps
    guard = 0;
    while (m_cnt < 300 && guard < 5000) begin rand_step(1'b0); guard++; end
    do_reset(1);
    guard = 0;
    while (!m_hold && guard < 5000) begin rand_step(1'b0); guard++; end
    chk("frame3_complete", int'(m_hold), 1);
    repeat (4) step(1'b0, '0, 1'b0);
    step(1'b1, ACC_W'($urandom), 1'b0);
    release_map();
    repeat (3) step(1'b0, '0, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
